// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Multi-digit 7-segment driver. A binary value loaded through a
//            load/ready handshake is converted to BCD by shift-add-3, then
//            the digits are time-multiplexed onto a shared segment bus with
//            optional leading-zero blanking and overflow dashes.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin,
  input  logic              blank_lz,
  output logic              ready,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_acc_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_conv = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  // Level that turns an anode or segment off on the board
  localparam logic c_off = (ACTIVE_LOW != 0);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Smallest value that no longer fits in DIGITS decimal digits
  localparam logic [63:0] c_ovf_limit = pow10(DIGITS);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [c_acc_w-1:0]  acc_q, acc_d;
  logic [c_acc_w-1:0]  acc_adj;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [c_acc_w-1:0]  disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [c_pre_w-1:0]  presc_q, presc_d;
  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [DIGITS-1:0]   zero_from;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_zero;
  logic                cur_blank;
  logic [6:0]          seg_ah;
  logic [DIGITS-1:0]   an_ah;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one CONV step per bit, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (load) state_d = c_conv;
      c_conv:  if (cnt_q == c_cnt_last) state_d = c_done;
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == c_idle);
  end

  // --------------------------------------------------------------------------
  // Double-dabble datapath and display register
  // --------------------------------------------------------------------------

  // Add 3 to every BCD nibble that is 5 or more ahead of the shift
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next values for the converter; the display only changes in DONE so a
  // partial result is never visible
  always_comb begin
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      c_idle: begin
        if (load) begin
          shift_d    = bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ({{(64-BIN_W){1'b0}}, bin} >= c_ovf_limit);
        end
      end
      c_conv: begin
        acc_d   = {acc_adj[c_acc_w-2:0], shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + c_cnt_w'(1);
      end
      c_done: begin
        disp_d = acc_q;
        ovf_d  = ovf_pend_q;
      end
      default: ;
    endcase
  end

  // Converter and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------

  // Prescaler wraps at SCAN_DIV-1 and steps the digit index on the wrap
  always_comb begin
    presc_d = presc_q + c_pre_w'(1);
    idx_d   = idx_q;
    if (presc_q == c_pre_last) begin
      presc_d = '0;
      idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_w'(1);
    end
  end

  // Prescaler and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Digit decode and output drive
  // --------------------------------------------------------------------------

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  // Active-high anode and segment pattern for the current digit
  always_comb begin
    cur_nib  = 4'd0;
    cur_zero = 1'b0;
    an_ah    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == c_idx_w'(i)) begin
        cur_nib  = disp_q[4*i +: 4];
        cur_zero = zero_from[i];
        an_ah[i] = 1'b1;
      end
    end
    cur_blank = blank_lz && (idx_q != '0) && cur_zero;

    case (cur_nib)
      4'd0:    seg_ah = 7'b0111111;
      4'd1:    seg_ah = 7'b0000110;
      4'd2:    seg_ah = 7'b1011011;
      4'd3:    seg_ah = 7'b1001111;
      4'd4:    seg_ah = 7'b1100110;
      4'd5:    seg_ah = 7'b1101101;
      4'd6:    seg_ah = 7'b1111101;
      4'd7:    seg_ah = 7'b0000111;
      4'd8:    seg_ah = 7'b1111111;
      4'd9:    seg_ah = 7'b1101111;
      default: seg_ah = 7'b0000000;
    endcase

    // Overflow dashes take priority over blanking
    if (ovf_q) begin
      seg_ah = 7'b1000000;
    end else if (cur_blank) begin
      seg_ah = 7'b0000000;
    end

    an_d  = an_ah  ^ {DIGITS{c_off}};
    seg_d = seg_ah ^ {7{c_off}};
  end

  // Registered display outputs, reset to the inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= {DIGITS{c_off}};
      seg_q <= {7{c_off}};
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed self-checking bench for seg7_scan_driver with a
//            scoreboard of expected anode/segment values per digit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              load     = 1'b0;
  logic [BIN_W-1:0]  bin      = '0;
  logic              blank_lz = 1'b0;
  logic              ready;
  logic              ovf;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  int tests  = 0;
  int failed = 0;
  int n;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  seg7_scan_driver #(
    .DIGITS    (DIGITS),
    .BIN_W     (BIN_W),
    .SCAN_DIV  (SCAN_DIV),
    .ACTIVE_LOW(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .bin     (bin),
    .blank_lz(blank_lz),
    .ready   (ready),
    .ovf     (ovf),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-low segment pattern expected for digit k of a value
  function automatic logic [6:0] model_seg(input int value, input bit blank, input int k);
    int p;
    int d;
    logic [6:0] ah;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    d = (value / p) % 10;
    case (d)
      0: ah = 7'b0111111;
      1: ah = 7'b0000110;
      2: ah = 7'b1011011;
      3: ah = 7'b1001111;
      4: ah = 7'b1100110;
      5: ah = 7'b1101101;
      6: ah = 7'b1111101;
      7: ah = 7'b0000111;
      8: ah = 7'b1111111;
      default: ah = 7'b1101111;
    endcase
    if (value >= 10000)                  ah = 7'b1000000;
    else if (blank && k > 0 && value < p) ah = 7'b0000000;
    return ~ah;
  endfunction

  function automatic logic [3:0] an_for(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  task automatic push_display(input int value, input bit blank);
    exp_t x;
    for (int k = 0; k < DIGITS; k++) begin
      x.an  = an_for(k);
      x.seg = model_seg(value, blank, k);
      sb.push_back(x);
    end
  endtask

  // Bounded wait for a given anode pattern
  task automatic wait_an(input logic [3:0] target);
    for (int i = 0; i < 40; i++) begin
      if (an === target) return;
      tick();
    end
  endtask

  task automatic check_display(input string tag);
    exp_t x;
    for (int k = 0; k < DIGITS; k++) begin
      x = sb.pop_front();
      wait_an(x.an);
      check({tag, " an"}, 32'(an), 32'(x.an));
      check({tag, " seg"}, 32'(seg), 32'(x.seg));
    end
  endtask

  task automatic do_load(input int value);
    bin  = BIN_W'(value);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    // Reset hold
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset ready", 32'(ready), 32'd1);
    check("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first edge an", 32'(an), 32'(4'b1110));
    check("first edge seg", 32'(seg), 32'(7'b1000000));

    // 1234
    blank_lz = 1'b0;
    do_load(1234);
    check("busy after load", 32'(ready), 32'd0);
    wait_ready(n);
    check("latency 1234", 32'(n), 32'd15);
    check("ovf 1234", 32'(ovf), 32'd0);
    tick();
    push_display(1234, 1'b0);
    check_display("d1234");

    // 7 with leading-zero blanking
    blank_lz = 1'b1;
    do_load(7);
    wait_ready(n);
    tick();
    push_display(7, 1'b1);
    check_display("d7blank");

    // Blanking release takes effect one cycle later
    wait_an(4'b1110);
    wait_an(4'b1101);
    blank_lz = 1'b0;
    tick();
    check("blank release an", 32'(an), 32'(4'b1101));
    check("blank release seg", 32'(seg), 32'(7'b1000000));

    // Overflow shows dashes regardless of blanking
    blank_lz = 1'b1;
    do_load(10000);
    wait_ready(n);
    check("latency 10000", 32'(n), 32'd15);
    check("ovf 10000", 32'(ovf), 32'd1);
    tick();
    push_display(10000, 1'b1);
    check_display("dovf");

    // 9999 clears overflow
    do_load(9999);
    wait_ready(n);
    check("ovf 9999", 32'(ovf), 32'd0);
    tick();
    push_display(9999, 1'b1);
    check_display("d9999");

    // 42 with an ignored load mid-conversion and bin changing
    blank_lz = 1'b0;
    do_load(42);
    repeat (4) tick();
    bin  = BIN_W'(99);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("busy ignore", 32'(ready), 32'd0);
    bin = BIN_W'(1111);
    wait_ready(n);
    check("latency after ignore", 32'(n), 32'd10);
    tick();
    push_display(42, 1'b0);
    check_display("d42");

    // Reset in the middle of a conversion
    do_load(5678);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midreset ready", 32'(ready), 32'd1);
    check("midreset an", 32'(an), 32'hF);
    check("midreset seg", 32'(seg), 32'h7F);
    check("midreset ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_display(0, 1'b0);
    check_display("d0000");

    // Free-running scan: each digit held exactly SCAN_DIV cycles
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int i = 0; i < 20; i++) begin
      e.an  = an_for((i / SCAN_DIV) % DIGITS);
      e.seg = 7'b1000000;
      sb.push_back(e);
    end
    for (int i = 0; i < 20; i++) begin
      e = sb.pop_front();
      check("scan an", 32'(an), 32'(e.an));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
